// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Moore-style control FSM for the multi-cycle CPU datapath. Each instruction
// walks FETCH -> DECODE -> (execute / branch / memory) -> write-back and
// then returns to FETCH. Illegal opcodes, including R-type with an unknown
// func field, park the FSM in HALT with a sticky illegal flag until reset.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous, active-high
//   instr          instruction register contents
//   alu_zero       ALU zero flag, used only to resolve beq/bne
//   ir_wren        load instruction register
//   pc_lden        load PC
//   pc_sel         0 = PC+4, 1 = PC+4+(immed<<2)
//   rf_wren        register file write enable (address instr[20:16])
//   rf_wrdata_sel  0 = alu_out, 1 = mem_out
//   rf_b_sel       0 = read instr[15:11], 1 = read instr[20:16]
//   alu_bin_sel    0 = rfb, 1 = immed
//   alu_a_zero     force ALU A operand to 0
//   alu_func       ALU operation
//   mem_wren       data memory write
//   mem_byte       byte access (lb/sb)
//   illegal        sticky illegal-instruction flag
//   state_dbg      current state encoding
// ---------------------------------------------------------------------------
module multicycle_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        alu_zero,
    output logic        ir_wren,
    output logic        pc_lden,
    output logic        pc_sel,
    output logic        rf_wren,
    output logic        rf_wrdata_sel,
    output logic        rf_b_sel,
    output logic        alu_bin_sel,
    output logic        alu_a_zero,
    output logic [3:0]  alu_func,
    output logic        mem_wren,
    output logic        mem_byte,
    output logic        illegal,
    output logic [3:0]  state_dbg
);

    // Opcode encodings (instr[31:26])
    localparam logic [5:0] OP_R    = 6'b100000;
    localparam logic [5:0] OP_LI   = 6'b111000;
    localparam logic [5:0] OP_LUI  = 6'b111001;
    localparam logic [5:0] OP_ADDI = 6'b110000;
    localparam logic [5:0] OP_ANDI = 6'b110010;
    localparam logic [5:0] OP_ORI  = 6'b110011;
    localparam logic [5:0] OP_B    = 6'b111111;
    localparam logic [5:0] OP_BEQ  = 6'b000000;
    localparam logic [5:0] OP_BNE  = 6'b000001;
    localparam logic [5:0] OP_LB   = 6'b000011;
    localparam logic [5:0] OP_LW   = 6'b001111;
    localparam logic [5:0] OP_SB   = 6'b000111;
    localparam logic [5:0] OP_SW   = 6'b011111;

    // ALU operation codes used directly by the FSM
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        EXEC_R   = 4'd3,
        EXEC_I   = 4'd4,
        BRANCH   = 4'd5,
        MEM_ADDR = 4'd6,
        MEM_RD   = 4'd7,
        MEM_WR   = 4'd8,
        WB_ALU   = 4'd9,
        WB_MEM   = 4'd10,
        HALT     = 4'd11
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [5:0] opcode;
    logic [5:0] func;

    logic is_r;
    logic r_func_ok;
    logic is_li;
    logic is_lui;
    logic is_addi;
    logic is_andi;
    logic is_ori;
    logic is_itype;
    logic is_b;
    logic is_beq;
    logic is_bne;
    logic is_branch;
    logic is_lb;
    logic is_lw;
    logic is_sb;
    logic is_sw;
    logic is_load;
    logic is_store;
    logic reads_rd;

    logic [3:0] i_alu_func;
    logic       i_a_zero;
    logic       branch_taken;

    // Raw enables before reset gating
    logic ir_wren_raw;
    logic pc_lden_raw;
    logic rf_wren_raw;
    logic mem_wren_raw;

    // Immediate, register-address and shift fields belong to the datapath
    logic unused_instr_bits;

    assign opcode            = instr[31:26];
    assign func              = instr[5:0];
    assign unused_instr_bits = ^instr[25:6];

    // Instruction classification from the IR contents
    always_comb begin
        is_r    = (opcode == OP_R);
        is_li   = (opcode == OP_LI);
        is_lui  = (opcode == OP_LUI);
        is_addi = (opcode == OP_ADDI);
        is_andi = (opcode == OP_ANDI);
        is_ori  = (opcode == OP_ORI);
        is_b    = (opcode == OP_B);
        is_beq  = (opcode == OP_BEQ);
        is_bne  = (opcode == OP_BNE);
        is_lb   = (opcode == OP_LB);
        is_lw   = (opcode == OP_LW);
        is_sb   = (opcode == OP_SB);
        is_sw   = (opcode == OP_SW);

        is_itype  = is_li | is_lui | is_addi | is_andi | is_ori;
        is_branch = is_b | is_beq | is_bne;
        is_load   = is_lb | is_lw;
        is_store  = is_sb | is_sw;

        // beq/bne compare against rd and stores write rd, so port B reads
        // the instr[20:16] field for these four
        reads_rd = is_beq | is_bne | is_sb | is_sw;

        r_func_ok = 1'b0;
        case (func)
            6'b110000, 6'b110001, 6'b110010, 6'b110011, 6'b110100,
            6'b111000, 6'b111001, 6'b111010, 6'b111100, 6'b111101:
                r_func_ok = 1'b1;
            default:
                r_func_ok = 1'b0;
        endcase

        // li/lui pass the immediate through an add with A forced to zero
        i_alu_func = ALU_ADD;
        if (is_andi) begin
            i_alu_func = ALU_AND;
        end else if (is_ori) begin
            i_alu_func = ALU_OR;
        end
        i_a_zero = is_li | is_lui;

        branch_taken = is_b | (is_beq & alu_zero) | (is_bne & ~alu_zero);
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore outputs; everything defaults to zero
    always_comb begin
        state_d       = state_q;
        ir_wren_raw   = 1'b0;
        pc_lden_raw   = 1'b0;
        pc_sel        = 1'b0;
        rf_wren_raw   = 1'b0;
        rf_wrdata_sel = 1'b0;
        rf_b_sel      = 1'b0;
        alu_bin_sel   = 1'b0;
        alu_a_zero    = 1'b0;
        alu_func      = ALU_ADD;
        mem_wren_raw  = 1'b0;
        mem_byte      = 1'b0;
        illegal       = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end

            FETCH: begin
                ir_wren_raw = 1'b1;
                state_d     = DECODE;
            end

            DECODE: begin
                rf_b_sel = reads_rd;
                if (is_r && r_func_ok) begin
                    state_d = EXEC_R;
                end else if (is_itype) begin
                    state_d = EXEC_I;
                end else if (is_branch) begin
                    state_d = BRANCH;
                end else if (is_load || is_store) begin
                    state_d = MEM_ADDR;
                end else begin
                    state_d = HALT;
                end
            end

            EXEC_R: begin
                alu_func = instr[3:0];
                state_d  = WB_ALU;
            end

            EXEC_I: begin
                alu_bin_sel = 1'b1;
                alu_func    = i_alu_func;
                alu_a_zero  = i_a_zero;
                state_d     = WB_ALU;
            end

            // The ALU result is still being written, so the EXEC-stage
            // controls are recreated from the opcode and held here
            WB_ALU: begin
                rf_wren_raw = 1'b1;
                pc_lden_raw = 1'b1;
                if (is_r) begin
                    alu_func = instr[3:0];
                end else begin
                    alu_bin_sel = 1'b1;
                    alu_func    = i_alu_func;
                    alu_a_zero  = i_a_zero;
                end
                state_d = FETCH;
            end

            BRANCH: begin
                rf_b_sel    = reads_rd;
                alu_func    = ALU_SUB;
                pc_lden_raw = 1'b1;
                pc_sel      = branch_taken;
                state_d     = FETCH;
            end

            MEM_ADDR: begin
                rf_b_sel    = reads_rd;
                alu_bin_sel = 1'b1;
                alu_func    = ALU_ADD;
                state_d     = is_load ? MEM_RD : MEM_WR;
            end

            MEM_RD: begin
                alu_bin_sel = 1'b1;
                alu_func    = ALU_ADD;
                mem_byte    = is_lb;
                state_d     = WB_MEM;
            end

            MEM_WR: begin
                rf_b_sel     = reads_rd;
                alu_bin_sel  = 1'b1;
                alu_func     = ALU_ADD;
                mem_wren_raw = 1'b1;
                mem_byte     = is_sb;
                pc_lden_raw  = 1'b1;
                state_d      = FETCH;
            end

            WB_MEM: begin
                rf_wren_raw   = 1'b1;
                rf_wrdata_sel = 1'b1;
                mem_byte      = is_lb;
                pc_lden_raw   = 1'b1;
                state_d       = FETCH;
            end

            HALT: begin
                illegal = 1'b1;
                state_d = HALT;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A reset landing mid-instruction must not let any write or load
    // through on that edge, so the enables are masked while reset is high
    assign ir_wren   = ir_wren_raw  & ~reset;
    assign pc_lden   = pc_lden_raw  & ~reset;
    assign rf_wren   = rf_wren_raw  & ~reset;
    assign mem_wren  = mem_wren_raw & ~reset;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//
// Table-driven check of the control FSM. Each record gives the inputs for
// one clock cycle plus the expected state and output vector for that cycle.
// Sequences cover reset, R/I-type, branches, loads, stores, a reset landing
// mid-instruction and both kinds of illegal instruction.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic        alu_zero;
    logic        ir_wren;
    logic        pc_lden;
    logic        pc_sel;
    logic        rf_wren;
    logic        rf_wrdata_sel;
    logic        rf_b_sel;
    logic        alu_bin_sel;
    logic        alu_a_zero;
    logic [3:0]  alu_func;
    logic        mem_wren;
    logic        mem_byte;
    logic        illegal;
    logic [3:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    // Output vector bit positions:
    // 14 ir_wren, 13 pc_lden, 12 pc_sel, 11 rf_wren, 10 rf_wrdata_sel,
    // 9 rf_b_sel, 8 alu_bin_sel, 7 alu_a_zero, 6:3 alu_func,
    // 2 mem_wren, 1 mem_byte, 0 illegal
    localparam logic [14:0] IR   = 15'h4000;
    localparam logic [14:0] PCL  = 15'h2000;
    localparam logic [14:0] PCS  = 15'h1000;
    localparam logic [14:0] RFW  = 15'h0800;
    localparam logic [14:0] WDS  = 15'h0400;
    localparam logic [14:0] BSEL = 15'h0200;
    localparam logic [14:0] BIN  = 15'h0100;
    localparam logic [14:0] AZ   = 15'h0080;
    localparam logic [14:0] F1   = 15'h0008;
    localparam logic [14:0] F3   = 15'h0018;
    localparam logic [14:0] F8   = 15'h0040;
    localparam logic [14:0] MW   = 15'h0004;
    localparam logic [14:0] MB   = 15'h0002;
    localparam logic [14:0] ILL  = 15'h0001;
    localparam logic [14:0] NONE = 15'h0000;

    localparam logic [31:0] I_ADD  = 32'h8023_1030;
    localparam logic [31:0] I_SUB  = 32'h8000_0031;
    localparam logic [31:0] I_SRA  = 32'h8000_0038;
    localparam logic [31:0] I_LI   = 32'hE000_0000;
    localparam logic [31:0] I_ORI  = 32'hCC00_0000;
    localparam logic [31:0] I_BEQ  = 32'h0022_0004;
    localparam logic [31:0] I_BNE  = 32'h0400_0000;
    localparam logic [31:0] I_B    = 32'hFC00_0000;
    localparam logic [31:0] I_LB   = 32'h0C22_0008;
    localparam logic [31:0] I_LW   = 32'h3C00_0000;
    localparam logic [31:0] I_SW   = 32'h7C22_000C;
    localparam logic [31:0] I_SB   = 32'h1C00_0000;
    localparam logic [31:0] I_BAD  = 32'hA800_0000;
    localparam logic [31:0] I_BADR = 32'h8000_0000;

    typedef struct packed {
        logic        rst;
        logic [31:0] ins;
        logic        z;
        logic [3:0]  st;
        logic [14:0] outs;
    } vec_t;

    vec_t vecs[$];

    multicycle_control dut (
        .clk           (clk),
        .reset         (reset),
        .instr         (instr),
        .alu_zero      (alu_zero),
        .ir_wren       (ir_wren),
        .pc_lden       (pc_lden),
        .pc_sel        (pc_sel),
        .rf_wren       (rf_wren),
        .rf_wrdata_sel (rf_wrdata_sel),
        .rf_b_sel      (rf_b_sel),
        .alu_bin_sel   (alu_bin_sel),
        .alu_a_zero    (alu_a_zero),
        .alu_func      (alu_func),
        .mem_wren      (mem_wren),
        .mem_byte      (mem_byte),
        .illegal       (illegal),
        .state_dbg     (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void push(input logic r, input logic [31:0] ins,
                                 input logic z, input logic [3:0] st,
                                 input logic [14:0] outs);
        vec_t v;
        v.rst  = r;
        v.ins  = ins;
        v.z    = z;
        v.st   = st;
        v.outs = outs;
        vecs.push_back(v);
    endfunction

    task automatic apply_stimulus(input vec_t v);
        reset    = v.rst;
        instr    = v.ins;
        alu_zero = v.z;
    endtask

    task automatic check_output(input int idx, input vec_t v);
        logic [14:0] got;
        got = {ir_wren, pc_lden, pc_sel, rf_wren, rf_wrdata_sel, rf_b_sel,
               alu_bin_sel, alu_a_zero, alu_func, mem_wren, mem_byte, illegal};
        checks++;
        if (state_dbg !== v.st) begin
            errors++;
            $display("[TB] FAIL vec%0d state: got %0d want %0d", idx, state_dbg, v.st);
        end
        checks++;
        if (got !== v.outs) begin
            errors++;
            $display("[TB] FAIL vec%0d outputs (instr %h): got %h want %h",
                     idx, v.ins, got, v.outs);
        end
    endtask

    initial begin
        // Reset held, then released: IDLE, FETCH, DECODE
        push(1, I_ADD, 0, 0, NONE);
        push(1, I_ADD, 0, 0, NONE);
        push(0, I_ADD, 0, 0, NONE);
        // add r3,r1,r2
        push(0, I_ADD, 0, 1, IR);
        push(0, I_ADD, 0, 2, NONE);
        push(0, I_ADD, 0, 3, NONE);
        push(0, I_ADD, 0, 9, RFW | PCL);
        // sub, sra: alu_func follows instr[3:0] and is held in WB_ALU
        push(0, I_SUB, 0, 1, IR);
        push(0, I_SUB, 0, 2, NONE);
        push(0, I_SUB, 0, 3, F1);
        push(0, I_SUB, 0, 9, RFW | PCL | F1);
        push(0, I_SRA, 0, 1, IR);
        push(0, I_SRA, 0, 2, NONE);
        push(0, I_SRA, 0, 3, F8);
        push(0, I_SRA, 0, 9, RFW | PCL | F8);
        // li forces A to zero; ori uses the OR function
        push(0, I_LI, 0, 1, IR);
        push(0, I_LI, 0, 2, NONE);
        push(0, I_LI, 0, 4, BIN | AZ);
        push(0, I_LI, 0, 9, RFW | PCL | BIN | AZ);
        push(0, I_ORI, 0, 1, IR);
        push(0, I_ORI, 0, 2, NONE);
        push(0, I_ORI, 0, 4, BIN | F3);
        push(0, I_ORI, 0, 9, RFW | PCL | BIN | F3);
        // beq taken / not taken, bne taken / not taken, b always taken
        push(0, I_BEQ, 1, 1, IR);
        push(0, I_BEQ, 1, 2, BSEL);
        push(0, I_BEQ, 1, 5, BSEL | F1 | PCL | PCS);
        push(0, I_BEQ, 0, 1, IR);
        push(0, I_BEQ, 0, 2, BSEL);
        push(0, I_BEQ, 0, 5, BSEL | F1 | PCL);
        push(0, I_BNE, 0, 1, IR);
        push(0, I_BNE, 0, 2, BSEL);
        push(0, I_BNE, 0, 5, BSEL | F1 | PCL | PCS);
        push(0, I_BNE, 1, 1, IR);
        push(0, I_BNE, 1, 2, BSEL);
        push(0, I_BNE, 1, 5, BSEL | F1 | PCL);
        push(0, I_B, 0, 1, IR);
        push(0, I_B, 0, 2, NONE);
        push(0, I_B, 0, 5, F1 | PCL | PCS);
        // lb: five cycles, byte access in MEM_RD and WB_MEM
        push(0, I_LB, 0, 1, IR);
        push(0, I_LB, 0, 2, NONE);
        push(0, I_LB, 0, 6, BIN);
        push(0, I_LB, 0, 7, BIN | MB);
        push(0, I_LB, 0, 10, RFW | WDS | MB | PCL);
        // lw: word access
        push(0, I_LW, 0, 1, IR);
        push(0, I_LW, 0, 2, NONE);
        push(0, I_LW, 0, 6, BIN);
        push(0, I_LW, 0, 7, BIN);
        push(0, I_LW, 0, 10, RFW | WDS | PCL);
        // sw and sb: four cycles, single write in MEM_WR
        push(0, I_SW, 0, 1, IR);
        push(0, I_SW, 0, 2, BSEL);
        push(0, I_SW, 0, 6, BSEL | BIN);
        push(0, I_SW, 0, 8, BSEL | BIN | MW | PCL);
        push(0, I_SB, 0, 1, IR);
        push(0, I_SB, 0, 2, BSEL);
        push(0, I_SB, 0, 6, BSEL | BIN);
        push(0, I_SB, 0, 8, BSEL | BIN | MW | MB | PCL);
        // Reset during WB_ALU: enables masked, FSM restarts from IDLE
        push(0, I_SUB, 0, 1, IR);
        push(0, I_SUB, 0, 2, NONE);
        push(0, I_SUB, 0, 3, F1);
        push(1, I_SUB, 0, 9, F1);
        push(0, I_SUB, 0, 0, NONE);
        // Illegal opcode: sticky HALT for 20 cycles, reset clears it
        push(0, I_BAD, 0, 1, IR);
        push(0, I_BAD, 0, 2, NONE);
        for (int i = 0; i < 20; i++) push(0, I_BAD, i[0], 11, ILL);
        push(1, I_BAD, 0, 11, ILL);
        push(0, I_BAD, 0, 0, NONE);
        // R-type with func 000000 also halts
        push(0, I_BADR, 0, 1, IR);
        push(0, I_BADR, 0, 2, NONE);
        for (int i = 0; i < 5; i++) push(0, I_BADR, 0, 11, ILL);
        push(1, I_BADR, 0, 11, ILL);
        push(0, I_ADD, 0, 0, NONE);
        push(0, I_ADD, 0, 1, IR);

        reset    = 1'b1;
        instr    = 32'h0;
        alu_zero = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            apply_stimulus(vecs[i]);
            #1;
            check_output(i, vecs[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
